// File: rtl/iir_lpf_mc.sv
// ---------------------------------------------------------------------------
// iir_lpf_mc
//
// Time-multiplexed, multi-channel first-order IIR low-pass (leaky integrator)
// for the audio path. Samples from up to CHANNELS sources share one adder
// through a two-stage pipeline. Each channel keeps its own accumulator and a
// runtime-programmable smoothing shift.
//
//   acc_new = acc + ((x << MAX_SHIFT) - acc) >>> shift
//
// The accumulator carries MAX_SHIFT fraction bits, so its scale never depends
// on the active shift. A shift can therefore be reprogrammed at any time
// without rescaling the stored state. A shift of 0 bypasses the filter.
//
// Parameters
//   WIDTH         sample width in and out
//   CHANNELS      number of independent channels (>= 1)
//   SHIFT_W       width of the per-channel shift field
//   DEFAULT_SHIFT shift loaded into every channel at reset (<= 2^SHIFT_W-1)
//   SIGNED        0: unsigned samples, 1: two's complement samples
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   clk_en     sample-rate strobe; gates acceptance only
//   clear      synchronous pulse, zeroes all accumulators and flushes pipeline
//   in_valid   a sample is offered
//   in_ready   clk_en && !clear
//   in_ch      channel of the offered sample
//   in_data    sample value
//   cfg_we     write cfg_shift into channel cfg_ch
//   cfg_ch     channel to configure
//   cfg_shift  new shift value (0 = bypass)
//   out_valid  one-cycle pulse per filtered result
//   out_ch     channel of the result
//   out_data   filtered sample
// ---------------------------------------------------------------------------
module iir_lpf_mc #(
  parameter int WIDTH         = 16,
  parameter int CHANNELS      = 4,
  parameter int SHIFT_W       = 3,
  parameter int DEFAULT_SHIFT = 4,
  parameter int SIGNED        = 0,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch,
  output logic [WIDTH-1:0]   out_data
);

  localparam int MAX_SHIFT = (1 << SHIFT_W) - 1;
  localparam int AW        = WIDTH + MAX_SHIFT;
  // State arrays cover the full index space of the channel field, so an
  // out-of-range channel number never indexes past the end of an array.
  localparam int DEPTH     = 1 << CH_W;

  localparam logic [CH_W:0]      CH_LIMIT  = (CH_W + 1)'(CHANNELS);
  localparam logic [SHIFT_W-1:0] RST_SHIFT = SHIFT_W'(DEFAULT_SHIFT);

  // Sample scaled into accumulator fixed point, one guard bit on top so the
  // difference against the accumulator cannot overflow.
  function automatic logic signed [AW:0] target_of(input logic [WIDTH-1:0] x);
    logic ext;
    ext = (SIGNED != 0) ? x[WIDTH-1] : 1'b0;
    return {ext, x, {MAX_SHIFT{1'b0}}};
  endfunction

  // One leaky-integrator update. The result always lies between a and t, so
  // it fits in AW bits and the modular AW-bit add is exact.
  function automatic logic [AW-1:0] leaky_step(input logic [AW-1:0]        a,
                                               input logic signed [AW:0]   t,
                                               input logic [SHIFT_W-1:0]   s);
    logic signed [AW:0] a_ext;
    logic signed [AW:0] d;
    a_ext = {(SIGNED != 0) ? a[AW-1] : 1'b0, a};
    d     = t - a_ext;
    return a + AW'(d >>> s);
  endfunction

  logic [AW-1:0]      acc_q   [DEPTH];
  logic [SHIFT_W-1:0] shift_q [DEPTH];

  logic               accept;
  logic               cfg_ok;
  logic               fwd;
  logic [AW-1:0]      a_sel;

  logic               vld_p0;
  logic [CH_W-1:0]    ch_p0;
  logic [WIDTH-1:0]   x_p0;
  logic [SHIFT_W-1:0] s_p0;
  logic [AW-1:0]      a_p0;
  logic [AW-1:0]      acc_new_p0;

  logic               vld_p1;
  logic [CH_W-1:0]    ch_p1;
  logic [WIDTH-1:0]   data_p1;

  assign in_ready = clk_en & ~clear;
  assign accept   = in_valid & in_ready & ({1'b0, in_ch} < CH_LIMIT);
  assign cfg_ok   = cfg_we & ({1'b0, cfg_ch} < CH_LIMIT);

  // The accumulator written back this cycle is not yet visible in acc_q, so a
  // same-channel sample arriving now takes the freshly computed value.
  assign fwd   = vld_p0 & (ch_p0 == in_ch);
  assign a_sel = fwd ? acc_new_p0 : acc_q[in_ch];

  // ---- stage A: capture channel, sample, shift and accumulator -----------
  always_ff @(posedge clk) begin
    if (accept) begin
      ch_p0 <= in_ch;
      x_p0  <= in_data;
      s_p0  <= shift_q[in_ch];
      a_p0  <= a_sel;
    end
  end

  // ---- stage B: update, write back, register result -----------------------
  assign acc_new_p0 = leaky_step(a_p0, target_of(x_p0), s_p0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      ch_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0 & ~clear;
      if (vld_p0 & ~clear) begin
        ch_p1   <= ch_p0;
        data_p1 <= acc_new_p0[AW-1:MAX_SHIFT];
      end
    end
  end

  // clear wins over the write-back of a sample still in stage B.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
    end else if (vld_p0) begin
      acc_q[ch_p0] <= acc_new_p0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) shift_q[i] <= RST_SHIFT;
    end else if (cfg_ok) begin
      shift_q[cfg_ch] <= cfg_shift;
    end
  end

  assign out_valid = vld_p1;
  assign out_ch    = ch_p1;
  assign out_data  = data_p1;

endmodule

// File: tb/tb_iir_lpf_mc.sv
// Bench for iir_lpf_mc: one unsigned 4-channel instance and one signed
// 3-channel instance share all inputs; a per-instance scoreboard holds the
// expected result, channel and arrival cycle of every accepted sample.
module tb_iir_lpf_mc;

  localparam int NU = 4;
  localparam int NS = 3;

  typedef struct {
    int ch;
    int data;
    int cyc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        clk_en;
  logic        clear;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [15:0] in_data;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [2:0]  cfg_shift;

  logic        in_ready_u, out_valid_u;
  logic [1:0]  out_ch_u;
  logic [15:0] out_data_u;
  logic        in_ready_s, out_valid_s;
  logic [1:0]  out_ch_s;
  logic [15:0] out_data_s;

  iir_lpf_mc #(.WIDTH(16), .CHANNELS(NU), .SHIFT_W(3), .DEFAULT_SHIFT(4), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_ch(in_ch), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_shift(cfg_shift),
    .out_valid(out_valid_u), .out_ch(out_ch_u), .out_data(out_data_u)
  );

  iir_lpf_mc #(.WIDTH(16), .CHANNELS(NS), .SHIFT_W(3), .DEFAULT_SHIFT(4), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_ch(in_ch), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_shift(cfg_shift),
    .out_valid(out_valid_s), .out_ch(out_ch_s), .out_data(out_data_s)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc   = 0;
  exp_t   qu[$];
  exp_t   qs[$];
  longint accu[NU];
  longint accs[NS];
  int     shu[NU];
  int     shs[NS];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference leaky integrator on plain integers, 7 fraction bits.
  function automatic longint lpf(input longint a, input longint x, input int s);
    longint d;
    d = x * 128 - a;
    return a + (d >>> s);
  endfunction

  function automatic int out16(input longint a);
    return int'((a >>> 7) & 64'hFFFF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NU; i++) begin accu[i] = 0; shu[i] = 4; end
    for (int i = 0; i < NS; i++) begin accs[i] = 0; shs[i] = 4; end
    qu.delete();
    qs.delete();
  endtask

  // One clock of stimulus. exu/exs >= 0 override the model's expected output.
  task automatic step(input bit v, input int ch, input int data, input bit we,
                      input int cch, input int csh, input bit ce, input bit clr,
                      input int exu, input int exs);
    exp_t e;
    logic signed [15:0] d16;
    @(negedge clk);
    in_valid  = v;
    in_ch     = 2'(ch);
    in_data   = 16'(data);
    cfg_we    = we;
    cfg_ch    = 2'(cch);
    cfg_shift = 3'(csh);
    clk_en    = ce;
    clear     = clr;
    #1;
    chk("in_ready_u", longint'(in_ready_u), longint'(ce && !clr));
    chk("in_ready_s", longint'(in_ready_s), longint'(ce && !clr));
    if (v && ce && !clr) begin
      d16      = 16'(data);
      accu[ch] = lpf(accu[ch], longint'(data & 'hFFFF), shu[ch]);
      e.ch     = ch;
      e.cyc    = cyc + 2;
      e.data   = (exu >= 0) ? exu : out16(accu[ch]);
      qu.push_back(e);
      if (ch < NS) begin
        accs[ch] = lpf(accs[ch], longint'(d16), shs[ch]);
        e.data   = (exs >= 0) ? exs : out16(accs[ch]);
        qs.push_back(e);
      end
    end
    if (we) begin
      shu[cch] = csh;
      if (cch < NS) shs[cch] = csh;
    end
    if (clr) begin
      for (int i = 0; i < NU; i++) accu[i] = 0;
      for (int i = 0; i < NS; i++) accs[i] = 0;
      qu.delete();
      qs.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0, -1, -1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (qu.size() != 0 || qs.size() != 0); i++) @(negedge clk);
    #2;
    chk("drain_u", qu.size(), 0);
    chk("drain_s", qs.size(), 0);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t eu;
    exp_t es;
    if (out_valid_u) begin
      if (qu.size() == 0) chk("unexpected_u", 1, 0);
      else begin
        eu = qu.pop_front();
        chk("data_u", out_data_u, eu.data);
        chk("ch_u", out_ch_u, eu.ch);
        chk("latency_u", cyc, eu.cyc);
      end
    end
    if (out_valid_s) begin
      if (qs.size() == 0) chk("unexpected_s", 1, 0);
      else begin
        es = qs.pop_front();
        chk("data_s", out_data_s, es.data);
        chk("ch_s", out_ch_s, es.ch);
        chk("latency_s", cyc, es.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; clk_en = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_ch = '0; in_data = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_shift = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid_u", out_valid_u, 0);
    chk("rst_ch_u", out_ch_u, 0);
    chk("rst_data_u", out_data_u, 0);
    chk("rst_valid_s", out_valid_s, 0);
    chk("rst_ch_s", out_ch_s, 0);
    chk("rst_data_s", out_data_s, 0);
    reset_n = 1'b1;

    // Handshake: sample offered without clk_en is ignored.
    step(1, 0, 'h1111, 0, 0, 0, 0, 0, -1, -1);
    step(1, 2, 'h2222, 0, 0, 0, 0, 0, -1, -1);
    idle(4);

    // Bypass on ch1.
    step(0, 0, 0, 1, 1, 0, 1, 0, -1, -1);
    step(1, 1, 'h1234, 0, 0, 0, 1, 0, 'h1234, 'h1234);
    idle(1);
    drain();

    // Step response on ch0, one accept per 8 clocks.
    step(0, 0, 0, 1, 0, 1, 1, 0, -1, -1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h4000, -1);
    repeat (7) step(1, 0, 'h8000, 0, 0, 0, 0, 0, -1, -1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h6000, -1);
    repeat (7) step(1, 0, 'h8000, 0, 0, 0, 0, 0, -1, -1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h7000, -1);
    repeat (7) step(1, 0, 'h8000, 0, 0, 0, 0, 0, -1, -1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h7800, -1);
    idle(1);
    drain();

    // Forwarding: four back-to-back samples on ch2.
    step(0, 0, 0, 1, 2, 2, 1, 0, -1, -1);
    step(1, 2, 'h0400, 0, 0, 0, 1, 0, 'h0100, 'h0100);
    step(1, 2, 'h0400, 0, 0, 0, 1, 0, 'h01C0, 'h01C0);
    step(1, 2, 'h0400, 0, 0, 0, 1, 0, 'h0250, 'h0250);
    step(1, 2, 'h0400, 0, 0, 0, 1, 0, 'h02BC, 'h02BC);
    idle(1);
    drain();

    // Isolation: ch0 step input interleaved with silent ch3.
    step(0, 0, 0, 0, 0, 0, 1, 1, -1, -1);
    step(0, 0, 0, 1, 3, 1, 1, 0, -1, -1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h4000, 'hC000);
    step(1, 3, 'h0000, 0, 0, 0, 1, 0, 'h0000, -1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h6000, 'hA000);
    step(1, 3, 'h0000, 0, 0, 0, 1, 0, 'h0000, -1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h7000, 'h9000);
    step(1, 3, 'h0000, 0, 0, 0, 1, 0, 'h0000, -1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h7800, 'h8800);
    // Config race: this sample still uses shift 1; the next one uses shift 3.
    step(1, 0, 'h8000, 1, 0, 3, 1, 0, 'h7C00, 'h8400);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, -1, -1);
    idle(1);
    drain();

    // Clear: flushes in-flight work and restarts the response.
    step(0, 0, 0, 0, 0, 0, 1, 1, -1, -1);
    step(0, 0, 0, 1, 0, 1, 1, 0, -1, -1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h4000, 'hC000);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h6000, 'hA000);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, -1, -1);
    step(0, 0, 0, 0, 0, 0, 1, 1, -1, -1);
    idle(1);
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h4000, 'hC000);
    idle(1);
    drain();

    // Randomised traffic across all channels, shifts and clk_en gaps.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 65535),
           $urandom_range(0, 9) == 0, $urandom_range(0, 3), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, 0, -1, -1);
    end
    idle(1);
    drain();

    // Asynchronous reset while a result is on the outputs.
    step(1, 1, 'h5000, 0, 0, 0, 1, 0, -1, -1);
    idle(1);
    @(posedge clk);
    #1;
    chk("valid_before_rst", out_valid_u, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid_u", out_valid_u, 0);
    chk("rst_mid_valid_s", out_valid_s, 0);
    chk("rst_mid_data_u", out_data_u, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    // Shifts are back at the default after reset.
    step(1, 0, 'h8000, 0, 0, 0, 1, 0, 'h0800, 'hF800);
    idle(1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iir_lpf_mc.md
# iir_lpf_mc

Time-multiplexed, multi-channel first-order IIR low-pass (leaky-integrator) filter for the audio path. Samples from up to CHANNELS sources share one adder through a 2-stage pipeline. Each channel has a runtime-programmable smoothing shift and its own accumulator. The filter smooths sound-generator outputs before mixing, replacing one fixed-gain filter instance per voice.

## Interface
- WIDTH, 16: sample width in and out.
- CHANNELS, 4: number of independent channels; ≥1.
- SHIFT_W, 3: width of the per-channel shift field; MAX_SHIFT = 2^SHIFT_W − 1.
- DEFAULT_SHIFT, 4: shift loaded into every channel at reset; must be ≤ MAX_SHIFT.
- SIGNED, 0: 0 means samples are unsigned; 1 means two's complement.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- clk_en, in, 1: sample-rate enable strobe.
- clear, in, 1: synchronous pulse that zeroes all accumulators.
- in_valid, in, 1: a sample is offered.
- in_ready, out, 1: equals clk_en && !clear.
- in_ch, in, clog2(CHANNELS) (min 1): channel of the offered sample.
- in_data, in, WIDTH: sample value.
- cfg_we, in, 1: write a shift value.
- cfg_ch, in, clog2(CHANNELS): channel to configure.
- cfg_shift, in, SHIFT_W: new shift; 0 means bypass.
- out_valid, out, 1: one-cycle pulse per filtered result.
- out_ch, out, clog2(CHANNELS): channel of the result.
- out_data, out, WIDTH: filtered sample.

## Operation
- State per channel:
  - acc[c] is AW = WIDTH + MAX_SHIFT bits, fixed point with MAX_SHIFT fraction bits.
  - shift[c] is SHIFT_W bits.
- Reset values: acc = 0; shift = DEFAULT_SHIFT; out_valid = 0; out_ch = 0; out_data = 0; both pipeline stages invalid.
- Accept: a sample is taken when in_valid && in_ready. Samples offered while in_ready is low are ignored; there is no stall or buffering.
- Stage A (accept cycle, registered at the clock edge):
  - Latches ch, x = in_data, s = shift[ch] and a = acc[ch].
  - Forwarding: if stage B writes the same channel in that cycle, a takes B's new value.
- Stage B (next cycle):
  - T = x << MAX_SHIFT, with x sign-extended when SIGNED=1 and zero-extended when SIGNED=0.
  - d = T − a, computed as a signed AW+1-bit value.
  - acc_new = a + (d >>> s), using an arithmetic shift.
  - Writes acc[ch] = acc_new.
  - Registers out_data = acc_new[AW−1:MAX_SHIFT], out_ch = ch, out_valid = 1.
- Range invariant: acc_new always lies between a and T inclusive, so no saturation logic exists and the value never wraps.
- Bypass: with s = 0, acc_new = T, so out_data equals x exactly.
- Shift changes need no rescaling, because the fixed-point scale does not depend on s.
- cfg_we writes shift[cfg_ch] at the clock edge. A sample accepted in the same cycle uses the old shift value, since stage A samples shift before the write.
- clear:
  - Zeroes every acc and invalidates stages A and B.
  - out_valid is 0 in the following cycle.
  - Has priority over any stage-B write-back in the same cycle.
  - Does not alter shift values.
- cfg_ch or in_ch ≥ CHANNELS: the write or sample is discarded; no state changes.

## Timing
- Latency: out_valid is high exactly 2 clk edges after the accept edge.
- Throughput: one sample per clk cycle while clk_en is held high.
- Back-to-back samples on the same channel give correct results, via forwarding from stage B to stage A.
- Pipeline stages advance on every clk; only acceptance is gated by clk_en.
- Asserting reset_n low mid-stream clears everything immediately, including an out_valid that is in flight.
- out_valid is never high in the first cycle after reset_n deasserts.

## Test plan
All scenarios use WIDTH=16, CHANNELS=4, SHIFT_W=3 unless stated.
- Reset / handshake: hold reset_n low, then release it → all outputs 0. With clk_en=1 and clear=0, in_ready=1. With clk_en=0, in_ready=0, and an offered sample produces no out_valid.
- Bypass: cfg ch1 to shift 0, then accept ch1 with 0x1234 → 2 cycles later out_valid=1, out_ch=1, out_data=0x1234.
- Step response: ch0 at shift 1, accept 0x8000 once per clk_en (every 8 clk) → out_data sequence 0x4000, 0x6000, 0x7000, 0x7800.
- Forwarding: ch2 at shift 2, accept 0x0400 on 4 consecutive clk (clk_en=1) → out_data 0x0100, 0x01C0, 0x0250, 0x02BC on 4 consecutive cycles.
- Isolation and config race:
  - Interleave ch0 and ch3 with shift 1, ch0 = 0x8000 and ch3 = 0x0000 → ch3 outputs stay 0 and ch0 follows the step sequence.
  - A cfg write to ch0 in the same cycle as a ch0 accept → that sample uses the old shift.
- SIGNED=1 and clear:
  - ch0 at shift 1, input 0x8000 → 0xC000, then 0xA000.
  - Pulse clear → the next ch0 sample of 0x8000 gives 0xC000 again, and no out_valid appears in the cycle after clear.
